// File: rtl/result_display.sv
// result_display: deserialises an LSB-first bit-serial result from the core
// into a holding register, then pages it onto 8 LEDs one byte at a time.
// The push button steps through the pages. Stepping past the last page
// releases the result and re-opens the serial input.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   btn_level  raw push button (asynchronous, active high)
//   ser_valid  core offers a result bit this cycle
//   ser_bit    result bit, LSB first
//   ser_last   marks the final bit (qualified by ser_valid)
//   ser_ready  block accepts a bit this cycle (registered)
//   led        displayed byte (registered)
//   page       index of the displayed byte, 0 = bits 7:0 (registered)
//   busy       a complete result is held for display (registered)
module result_display #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned PAGES = WIDTH / 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  input  logic       ser_valid,
  input  logic       ser_bit,
  input  logic       ser_last,
  output logic       ser_ready,
  output logic [7:0] led,
  output logic [1:0] page,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic {
    CAPTURE = 1'b0,
    SHOW    = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         page_q, page_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [7:0]         led_q, led_d;
  logic               sync0_q, sync1_q, prev_q;
  logic               btn_edge;
  logic [31:0]        hold_ext;

  // Button synchroniser and rising-edge detector, active in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync0_q <= btn_level;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
    end
  end

  assign btn_edge = sync1_q & ~prev_q;

  // Next-state logic; outputs are decoded from the next state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    unique case (state_q)
      CAPTURE: begin
        if (ser_valid) begin
          // Bits beyond WIDTH are handshaken but dropped; the counter saturates.
          if (cnt_q < CNT_W'(WIDTH)) begin
            hold_d[cnt_q[IDX_W-1:0]] = ser_bit;
            cnt_d                    = cnt_q + CNT_W'(1);
          end
          if (ser_last) begin
            state_d = SHOW;
            page_d  = 2'd0;
          end
        end
      end
      SHOW: begin
        if (btn_edge) begin
          if (page_q == 2'(PAGES - 1)) begin
            // Clearing hold here is what zero-extends the next short result.
            state_d = CAPTURE;
            hold_d  = '0;
            cnt_d   = '0;
            page_d  = 2'd0;
          end else begin
            page_d = page_q + 2'd1;
          end
        end
      end
      default: state_d = CAPTURE;
    endcase

    ready_d  = (state_d == CAPTURE);
    busy_d   = (state_d == SHOW);
    hold_ext = 32'(hold_d);
    led_d    = busy_d ? hold_ext[{page_d, 3'b000} +: 8] : 8'h00;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CAPTURE;
      hold_q  <= '0;
      cnt_q   <= '0;
      page_q  <= 2'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign ser_ready = ready_q;
  assign busy      = busy_q;
  assign led       = led_q;
  assign page      = page_q;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display (WIDTH=16) with a behavioural
// model: the expected display is the integer formed by the first WIDTH
// offered bits, read back a byte per page.
module tb_result_display;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned PAGES = WIDTH / 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_level;
  logic       ser_valid;
  logic       ser_bit;
  logic       ser_last;
  logic       ser_ready;
  logic [7:0] led;
  logic [1:0] page;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  result_display #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_level (btn_level),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .ser_last  (ser_last),
    .ser_ready (ser_ready),
    .led       (led),
    .page      (page),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: value of the stored result, first WIDTH bits, zero-extended.
  function automatic logic [7:0] model_byte(input logic [63:0] bits, input int n, input int pg);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n && i < int'(WIDTH); i++) v[i] = bits[i];
    return v[8*pg +: 8];
  endfunction

  // Offers n bits; ser_last on the final one when with_last. Returns handshakes.
  task automatic send_bits(input logic [63:0] bits, input int n, input bit with_last, output int hs);
    hs = 0;
    for (int i = 0; i < n; i++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (!ser_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      ser_valid = 1'b1;
      ser_bit   = bits[i];
      ser_last  = with_last && (i == n - 1);
      if (ser_ready) hs++;
      @(posedge clk);
    end
    @(negedge clk);
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    ser_bit   = 1'b0;
  endtask

  task automatic press();
    @(negedge clk);
    btn_level = 1'b1;
    @(negedge clk);
    btn_level = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Walks every page of a displayed result and expects CAPTURE afterwards.
  task automatic walk_result(input string name, input logic [63:0] bits, input int n);
    for (int pg = 0; pg < int'(PAGES); pg++) begin
      logic [7:0] exp_led;
      exp_led = model_byte(bits, n, pg);
      n_checks++;
      if (busy !== 1'b1 || ser_ready !== 1'b0 || page !== 2'(pg) || led !== exp_led) begin
        n_fail++;
        $display("FAIL %s page%0d: busy=%b ready=%b page=%0d led=%h, want busy=1 ready=0 page=%0d led=%h",
                 name, pg, busy, ser_ready, page, led, pg, exp_led);
      end
      press();
    end
    n_checks++;
    if (busy !== 1'b0 || ser_ready !== 1'b1 || page !== 2'd0 || led !== 8'h00) begin
      n_fail++;
      $display("FAIL %s release: busy=%b ready=%b page=%0d led=%h, want 0 1 0 00",
               name, busy, ser_ready, page, led);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_level = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0; ser_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ser_ready !== 1'b1 || busy !== 1'b0 || led !== 8'h00 || page !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: ready=%b busy=%b led=%h page=%0d, want 1 0 00 0", ser_ready, busy, led, page);
    end
    press();
    press();
    n_checks++;
    if (ser_ready !== 1'b1 || busy !== 1'b0 || led !== 8'h00 || page !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_press: ready=%b busy=%b led=%h page=%0d, want 1 0 00 0", ser_ready, busy, led, page);
    end
  endtask

  task automatic test_full_capture();
    int hs;
    send_bits(64'hA5C3, 16, 1'b1, hs);
    n_checks++;
    if (hs !== 16) begin
      n_fail++;
      $display("FAIL full_hs: got %0d handshakes, want 16", hs);
    end
    walk_result("full", 64'hA5C3, 16);
  endtask

  task automatic test_short();
    int hs;
    // Bits 1,0,1,1,1 LSB first -> 5'b11101 = 8'h1D.
    send_bits(64'h1D, 5, 1'b1, hs);
    n_checks++;
    if (led !== 8'h1D) begin
      n_fail++;
      $display("FAIL short_led: got %h, want 1d", led);
    end
    walk_result("short", 64'h1D, 5);
  endtask

  task automatic test_overlong();
    int hs;
    send_bits(64'hF_FFFF, 20, 1'b1, hs);
    n_checks++;
    if (hs !== 20) begin
      n_fail++;
      $display("FAIL overlong_hs: got %0d handshakes, want 20", hs);
    end
    walk_result("overlong", 64'hF_FFFF, 20);
  endtask

  task automatic test_button_timing();
    int hs;
    send_bits(64'h3C5A, 16, 1'b1, hs);
    // One-cycle press: edge N is the first posedge with the button high.
    @(negedge clk);
    btn_level = 1'b1;
    @(negedge clk);              // after N
    btn_level = 1'b0;
    @(negedge clk);              // after N+1
    n_checks++;
    if (page !== 2'd0) begin
      n_fail++;
      $display("FAIL btn_early: page=%0d at N+1, want 0", page);
    end
    @(negedge clk);              // after N+2
    n_checks++;
    if (page !== 2'd1 || led !== 8'h3C) begin
      n_fail++;
      $display("FAIL btn_step: page=%0d led=%h at N+2, want 1 3c", page, led);
    end
    repeat (3) @(negedge clk);
    // 50-cycle press on the last page releases the result once.
    btn_level = 1'b1;
    @(negedge clk);              // after N
    @(negedge clk);              // after N+1
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL btn_long_early: busy=%b at N+1, want 1", busy);
    end
    @(negedge clk);              // after N+2
    n_checks++;
    if (busy !== 1'b0 || page !== 2'd0 || ser_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL btn_long_step: busy=%b page=%0d ready=%b, want 0 0 1", busy, page, ser_ready);
    end
    repeat (47) @(negedge clk);
    btn_level = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || page !== 2'd0 || ser_ready !== 1'b1 || led !== 8'h00) begin
      n_fail++;
      $display("FAIL btn_release: busy=%b page=%0d ready=%b led=%h, want 0 0 1 00", busy, page, ser_ready, led);
    end
  endtask

  task automatic test_mid_reset();
    int hs;
    send_bits(64'h7F, 7, 1'b0, hs);
    do_reset();
    @(negedge clk);
    n_checks++;
    if (ser_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: ready=%b busy=%b, want 1 0", ser_ready, busy);
    end
    send_bits(64'h0001, 16, 1'b1, hs);
    walk_result("midreset", 64'h0001, 16);
    // Reset while showing page 1.
    send_bits(64'hBEEF, 16, 1'b1, hs);
    press();
    n_checks++;
    if (page !== 2'd1 || led !== 8'hBE) begin
      n_fail++;
      $display("FAIL show_page1: page=%0d led=%h, want 1 be", page, led);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (page !== 2'd0 || busy !== 1'b0 || ser_ready !== 1'b1 || led !== 8'h00) begin
      n_fail++;
      $display("FAIL show_reset: page=%0d busy=%b ready=%b led=%h, want 0 0 1 00", page, busy, ser_ready, led);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [63:0] bits;
      int n, hs;
      bits = {$urandom, $urandom};
      n    = int'($urandom_range(1, 24));
      send_bits(bits, n, 1'b1, hs);
      n_checks++;
      if (hs !== n) begin
        n_fail++;
        $display("FAIL rand%0d_hs: got %0d handshakes, want %0d", t, hs, n);
      end
      walk_result($sformatf("rand%0d", t), bits, n);
    end
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_short();
    test_overlong();
    test_button_timing();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/result_display.md
# result_display

Output-side counterpart of the DIP-switch/push-button instruction loader. It accepts the CPU core's bit-serial result (LSB first) through a valid/ready handshake and deserialises it into a holding register. It then shows that register on the 8 LED outputs one byte at a time, and the same external push button steps through the bytes. When the user steps past the last byte, the block releases the result and accepts the next one.

## Interface
Parameters:
- WIDTH, 16, result width in bits; must be a multiple of 8, range 8..32.
- PAGES, WIDTH/8, number of LED pages; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- btn_level  in  1  raw push button, asynchronous to clk, active high (uio_in[0]).
- ser_valid  in  1  core presents a result bit on ser_bit this cycle.
- ser_bit  in  1  result bit, LSB first.
- ser_last  in  1  qualifies the final bit of the result; meaningful only with ser_valid.
- ser_ready  out  1  block accepts a bit this cycle.
- led  out  8  displayed byte.
- page  out  2  index of the displayed byte (0 = bits 7:0).
- busy  out  1  a complete result is held for display.

## Operation
- Button path: two-flop synchroniser (sync0, sync1), then a prev flop.
  - btn_edge = sync1 & ~prev.
  - All three flops clear on reset.
  - The path runs in every state; there is no debounce beyond the edge detector.
- State CAPTURE (the reset state):
  - ser_ready=1, busy=0, led=8'h00, page=0.
  - On ser_valid, the bit is written to hold[bit_cnt] and bit_cnt increments.
  - Once bit_cnt reaches WIDTH, further bits are accepted and discarded, and bit_cnt saturates.
  - On ser_valid & ser_last, the last bit is stored per the rules above, the state goes to SHOW, and page=0.
  - Short results (fewer than WIDTH bits) are zero-extended, because hold is cleared on every entry to CAPTURE.
  - btn_edge is ignored.
- State SHOW:
  - ser_ready=0, busy=1, led = hold[8*page+7 : 8*page].
  - ser_valid is ignored; the core must stall.
  - btn_edge with page < PAGES-1: page increments.
  - btn_edge with page == PAGES-1: state goes to CAPTURE, hold is cleared, bit_cnt=0, page=0.
- Reset value of every output: ser_ready=1, led=8'h00, page=0, busy=0.
- Reset mid-operation: a low rst_n at any clock edge discards any partial or held result and returns to CAPTURE. A partial serial transfer is not resumed.

## Timing
- btn_level rising, sampled at edge N:
  - btn_edge is high during the cycle between edges N+1 and N+2.
  - page/state update at edge N+2.
  - One press yields exactly one step, regardless of hold duration.
- ser_ready is a registered state decode, so it is valid from the start of each cycle.
- Handshake completes at any edge where ser_valid & ser_ready; there is no combinational path from ser_valid to ser_ready.
- The bit sampled with ser_last at edge K is stored at edge K. From the cycle after edge K: busy=1, ser_ready=0, led shows byte 0.
- Final press: CAPTURE is entered at the action edge, and ser_ready=1 from the next cycle. A bit offered in that cycle is accepted into bit 0.
- In CAPTURE, btn_edge and ser_valid/ser_last coinciding: the button is ignored and the bit is processed.
- In SHOW, btn_edge and ser_valid coinciding: the button acts and the bit is dropped. The core must not offer bits while ser_ready=0.
- WIDTH=8: a single press in SHOW returns to CAPTURE.

## Test plan
- Reset/idle: hold rst_n low 2 cycles, release. Required: ser_ready=1, busy=0, led=00, page=0. Button presses in this state cause no change.
- Full capture (WIDTH=16): send 16'hA5C3 LSB first, with ser_last on bit 15. Required: busy=1 and led=C3 from the next cycle. Press: page=1, led=A5. Press: ser_ready=1, led=00, busy=0.
- Short result: send 5 bits 1,0,1,1,1, with ser_last on the 5th. Required: led=8'h1D, and page 1 shows 00.
- Overlong result: send 20 bits of 1 with ser_last on the 20th. Required: hold=16'hFFFF, and exactly 20 handshakes complete.
- Button timing: raise btn_level for 1 cycle, then for 50 cycles, in SHOW. Required: each press advances page exactly once, 2 edges after sampling. No advance on the falling edge.
- Reset mid-operation: assert rst_n low after 7 bits, release, then send 16'h0001. Required: led=01, with no residue from the aborted transfer. Repeat the reset while in SHOW with page=1: required page=0, busy=0.
